// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA raster path: pixel-format codes, default
// 800x600@60 timing, the {hs, vs, active} bundle and the RGB expansion helper.
package vga_timing_pkg;

    localparam int FMT_RGB555 = 0;
    localparam int FMT_RGB565 = 1;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 40;
    localparam int DEF_H_SYNC   = 128;
    localparam int DEF_H_BP     = 88;
    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FP     = 1;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BP     = 23;

    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
    } raster_bits_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Replicate the top bits of each channel into the low bits so full scale maps to 8'hFF.
    function automatic rgb888_t expand_pixel(input logic [15:0] p, input logic is_565);
        rgb888_t c;
        if (is_565) begin
            c.r = {p[15:11], p[15:13]};
            c.g = {p[10:5], p[10:9]};
        end else begin
            c.r = {p[14:10], p[14:12]};
            c.g = {p[9:5], p[9:7]};
        end
        c.b = {p[4:0], p[4:2]};
        return c;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register; flush reloads every stage with the idle value
// so stale raster bits never reach the pins after the raster stops.
module vga_delay_line #(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
        end else if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Pixel-clock raster generator: raw counters request pixels PIPE_LAT cycles
// ahead, and sync/blank are delayed to land in the same output register as the pixel.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE       = DEF_H_ACTIVE,
    parameter int H_FP           = DEF_H_FP,
    parameter int H_SYNC         = DEF_H_SYNC,
    parameter int H_BP           = DEF_H_BP,
    parameter int V_ACTIVE       = DEF_V_ACTIVE,
    parameter int V_FP           = DEF_V_FP,
    parameter int V_SYNC         = DEF_V_SYNC,
    parameter int V_BP           = DEF_V_BP,
    parameter int H_SYNC_POL     = 1,
    parameter int V_SYNC_POL     = 1,
    parameter int CNT_W          = 12,
    parameter int PIPE_LAT       = 1,
    parameter int PIX_FMT        = FMT_RGB555,
    parameter int PRESTART_LINES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic             pix_req,
    input  logic [15:0]      pix_data,
    input  logic             pix_valid,
    output logic [CNT_W-1:0] x_pos,
    output logic [CNT_W-1:0] y_pos,
    output logic             frame_done,
    output logic             frame_start,
    output logic             underflow,
    input  logic             underflow_clr,
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic             VGA_BLANK_N,
    output logic             VGA_SYNC_N,
    output logic [7:0]       VGA_R,
    output logic [7:0]       VGA_G,
    output logic [7:0]       VGA_B
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_DONE   = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_PRE    = CNT_W'(V_TOTAL - PRESTART_LINES);

    localparam logic         H_POL     = (H_SYNC_POL != 0);
    localparam logic         V_POL     = (V_SYNC_POL != 0);
    localparam logic         IS_565    = (PIX_FMT == FMT_RGB565);
    localparam raster_bits_t IDLE_BITS = '{hs: ~H_POL, vs: ~V_POL, active: 1'b0};

    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic             raw_active, hs_raw, vs_raw;
    raster_bits_t     raw_bits, dly_bits;

    logic    hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d, underflow_q, underflow_d;
    rgb888_t rgb_q, rgb_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (!enable) begin
            x_d = '0;
            y_d = '0;
        end else if (x_q == H_LAST) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? '0 : y_q + CNT_W'(1);
        end else begin
            x_d = x_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign raw_active = (x_q < H_ACT_C) && (y_q < V_ACT_C);
    assign hs_raw     = ((x_q >= HS_START) && (x_q < HS_END)) ? H_POL : ~H_POL;
    assign vs_raw     = ((y_q >= VS_START) && (y_q < VS_END)) ? V_POL : ~V_POL;

    // Counters sit at (0,0) during reset, which is an active position, so mask the request.
    assign pix_req     = raw_active & enable & ~reset;
    assign frame_done  = enable & (x_q == H_LAST) & (y_q == V_DONE);
    assign frame_start = enable & (x_q == H_LAST) & (y_q == V_PRE);
    assign x_pos       = x_q;
    assign y_pos       = y_q;

    assign raw_bits = '{hs: hs_raw, vs: vs_raw, active: raw_active & enable};

    vga_delay_line #(
        .WIDTH    ($bits(raster_bits_t)),
        .DEPTH    (PIPE_LAT),
        .RESET_VAL(IDLE_BITS)
    ) u_dly (
        .clk_i  (clk),
        .rst_i  (reset),
        .flush_i(~enable),
        .d_i    (raw_bits),
        .q_o    (dly_bits)
    );

    always_comb begin
        hs_d        = dly_bits.hs;
        vs_d        = dly_bits.vs;
        blank_n_d   = dly_bits.active;
        rgb_d       = '0;
        underflow_d = underflow_q & ~underflow_clr;
        if (dly_bits.active) begin
            if (pix_valid) rgb_d = expand_pixel(pix_data, IS_565);
            else           underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_q        <= ~H_POL;
            vs_q        <= ~V_POL;
            blank_n_q   <= 1'b0;
            rgb_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            blank_n_q   <= blank_n_d;
            rgb_q       <= rgb_d;
            underflow_q <= underflow_d;
        end
    end

    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_SYNC_N  = 1'b1;
    assign VGA_R       = rgb_q.r;
    assign VGA_G       = rgb_q.g;
    assign VGA_B       = rgb_q.b;
    assign underflow   = underflow_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised successor to the fixed-mode VGA driver timing path: a single-clock (pixel clock) raster generator with any resolution and porch set, per-axis sync polarity, two pixel formats, and a configurable fetch-to-pin pipeline. It sits between the pixel fetch path and the DAC pins. It issues `pix_req` one pipeline depth ahead, aligns sync and blank with the returned pixel, expands the pixel to 8-bit RGB, and flags underflow.

## Interface
Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP / H_SYNC / H_BP, 40 / 128 / 88, horizontal porches and sync width; H_TOTAL = sum of H_* (1056)
- V_ACTIVE, 600, visible lines
- V_FP / V_SYNC / V_BP, 1 / 4 / 23, vertical porches and sync width; V_TOTAL = sum of V_* (628)
- H_SYNC_POL / V_SYNC_POL, 1 / 1, asserted level of HS / VS
- CNT_W, 12, counter width; must satisfy 2^CNT_W ≥ max(H_TOTAL, V_TOTAL)
- PIPE_LAT, 1, cycles from `pix_req` to `pix_data`/`pix_valid` (≥1)
- PIX_FMT, 0, 0 = RGB555 (bit 15 ignored), 1 = RGB565
- PRESTART_LINES, 2, lines before raster wrap at which `frame_start` fires (1..V_BP+V_SYNC+V_FP)

Ports:
- clk  in  1  pixel clock; the only clock
- reset  in  1  asynchronous, active-high
- enable  in  1  raster runs while high
- pix_req  out  1  one pixel needed; data due PIPE_LAT cycles later
- pix_data  in  16  pixel word
- pix_valid  in  1  qualifies pix_data
- x_pos, y_pos  out  CNT_W  raw counter values, pre-pipeline
- frame_done  out  1  pulse: last active line finished
- frame_start  out  1  pulse: begin fetching next frame
- underflow  out  1  sticky: active pixel had no valid data
- underflow_clr  in  1  clears underflow
- VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N  out  1  pin timing; SYNC_N is constant 1
- VGA_R, VGA_G, VGA_B  out  8  expanded colour

## Operation
- The x counter runs 0..H_TOTAL-1 and wraps to 0. The y counter increments when x wraps and resets to 0 when x and y wrap together.
- Raw active region is x < H_ACTIVE and y < V_ACTIVE. `pix_req` equals raw active, combinational from the counters.
- HS is asserted at level H_SYNC_POL for H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC, otherwise at the opposite level. VS follows the same rule on y.
- `frame_done` is high for one cycle when x = H_TOTAL-1 and y = V_ACTIVE-1.
- `frame_start` is high for one cycle when x = H_TOTAL-1 and y = V_TOTAL-PRESTART_LINES.
- Raw HS, VS and active bits pass through a PIPE_LAT-stage delay line, then one output register. The pixel is captured into the same output register.
- Output stage, delayed active with `pix_valid`: RGB is expanded.
  - RGB555: R={p[14:10],p[14:12]}, G={p[9:5],p[9:7]}, B={p[4:0],p[4:2]}.
  - RGB565: R={p[15:11],p[15:13]}, G={p[10:5],p[10:9]}, B={p[4:0],p[4:2]}.
- Output stage, delayed active without `pix_valid`: RGB = 0, BLANK_N = 1, and `underflow` is set.
- Output stage, inactive: RGB = 0, BLANK_N = 0. `pix_valid` is ignored.
- `underflow_clr` clears `underflow`. If a new underflow occurs in the same cycle, set wins.
- `enable` low: counters are held at 0, `pix_req` and pulses are 0, and the delay line is flushed to inactive.
  - Pins then show blank with syncs at their inactive levels, PIPE_LAT+1 cycles after the fall.
  - The first cycle after `enable` rises is x=0, y=0.

## Timing
- Reset values: counters 0, `pix_req` 0, `frame_done`/`frame_start` 0, `underflow` 0, BLANK_N 0, RGB 0, HS = !H_SYNC_POL, VS = !V_SYNC_POL, delay line inactive.
- Pin latency from the raw counter state is exactly PIPE_LAT+1 cycles, for sync, blank and pixel alike.
- The pulses and `x_pos`/`y_pos` are raw; they are not delayed.
- Reset mid-frame: all state returns to reset values immediately, with no partial line. Raster restarts at (0,0) once reset is low and `enable` is high.
- `pix_valid` is sampled only in the output-register cycle of a delayed-active pixel.

## Structure
- Package `vga_timing_pkg`: pixel-format encodings (FMT_RGB555, FMT_RGB565) and the default 800x600@60 timing constants, for reuse by the fetch master and the testbench.
- Sub-module `vga_delay_line`:
  - WIDTH- and DEPTH-parametrised shift register with async active-high reset and synchronous flush.
  - Used for the {hs, vs, active} bundle.

## Test plan
- Default parameters, `pix_valid` always 1, run 2 frames: HS pulse 128 cycles wide starting at x=840; VS 4 lines starting at y=601; 1056×628 cycles per frame; `frame_done` at (1055,599); `frame_start` at (1055,626).
- PIPE_LAT=3, `pix_data` = x-coordinate stream: pin BLANK_N rises 4 cycles after the `pix_req` rise, and the first pixel shown is pixel 0.
- PIX_FMT=1, `pix_data`=16'hF81F: R=8'hFF, G=8'h00, B=8'hFF. PIX_FMT=0, `pix_data`=16'h7C00: R=8'hFF, G=8'h00, B=8'h00.
- Deassert `pix_valid` for one active cycle at (10,5): RGB 0 at that pin cycle, BLANK_N stays 1, `underflow` latches. Assert `underflow_clr` and a new underflow in the same cycle: `underflow` stays 1.
- H_SYNC_POL=0, V_SYNC_POL=0, small mode (H 8/2/2/2, V 4/1/1/1): HS idles high and drops for 2 cycles; VS idles high; reset values match the inverted levels.
- `enable` dropped mid-line at y=300, then reset pulsed during active: outputs blank within PIPE_LAT+1 cycles, or at once on reset. After the rise, the first `pix_req` occurs at (0,0).
